grf_wb_arbiter: RTL and testbench

Arbiter for the single write port of the general register file (GRF). It sits between the pipeline writeback stage and a long-latency result source (e.g. a multi-cycle multiply/divide or coprocessor unit) and serialises both onto one registered GRF write stage. Source B requests are buffered in a FIFO, and a scoreboard lets decode detect pending writes. A starvation counter requests a one-cycle pipeline freeze so buffered results always drain.

---
 rtl/grf_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
// Serialises two result sources onto the single GRF write port:
//   source A (pipeline writeback) is never back-pressured;
//   source B (long-latency unit) is buffered in a DEPTH-entry FIFO.
// A starvation counter raises a one-cycle pipeline freeze so that
// buffered B results always drain. A scoreboard reports pending writes.
// Ports:
//   clk, reset (async, active-low)
//   wbWE/wbWA/wbWD/wbPC         source A request
//   mdValid/mdReady/mdWA/mdWD/mdPC  source B request handshake
//   qA1/qA2 -> qBusy1/qBusy2    decode pending-write queries
//   qCount                      FIFO occupancy
//   pipeStall                   registered freeze request
//   regWE/regWA/regWD/PC        registered GRF write port
module grf_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wbWE,
    input  logic [4:0]                 wbWA,
    input  logic [31:0]                wbWD,
    input  logic [31:0]                wbPC,
    input  logic                       mdValid,
    output logic                       mdReady,
    input  logic [4:0]                 mdWA,
    input  logic [31:0]                mdWD,
    input  logic [31:0]                mdPC,
    input  logic [4:0]                 qA1,
    input  logic [4:0]                 qA2,
    output logic                       qBusy1,
    output logic                       qBusy2,
    output logic [$clog2(DEPTH):0]     qCount,
    output logic                       pipeStall,
    output logic                       regWE,
    output logic [4:0]                 regWA,
    output logic [31:0]                regWD,
    output logic [31:0]                PC
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [7:0]    WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [4:0]    wa_mem_q [DEPTH];
    logic [31:0]   wd_mem_q [DEPTH];
    logic [31:0]   pc_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    wait_q, wait_d;
    logic          stall_q, stall_d;
    logic          reg_we_q, reg_we_d;
    logic [4:0]    reg_wa_q, reg_wa_d;
    logic [31:0]   reg_wd_q, reg_wd_d;
    logic [31:0]   reg_pc_q, reg_pc_d;

    logic          push_s;
    logic          grant_a_s;
    logic          pop_s;
    logic          hit1_s, hit2_s;
    logic [AW-1:0] idx_s;

    // mdReady ignores a same-cycle pop: a full FIFO always refuses.
    assign mdReady   = reset && (count_q < DEPTH_C);
    assign qCount    = count_q;
    assign pipeStall = stall_q;
    assign regWE     = reg_we_q;
    assign regWA     = reg_wa_q;
    assign regWD     = reg_wd_q;
    assign PC        = reg_pc_q;

    // Grant selection and FIFO pointer/occupancy next state.
    always_comb begin
        push_s    = mdValid && mdReady;
        grant_a_s = wbWE && !stall_q;
        pop_s     = !grant_a_s && (count_q != {CW{1'b0}});
        wr_ptr_d  = wr_ptr_q + (push_s ? {{(AW-1){1'b0}}, 1'b1} : {AW{1'b0}});
        rd_ptr_d  = rd_ptr_q + (pop_s  ? {{(AW-1){1'b0}}, 1'b1} : {AW{1'b0}});
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Starvation counter; a freeze always yields a pop next cycle, so
    // the stall self-clears after exactly one cycle.
    always_comb begin
        wait_d  = wait_q;
        stall_d = 1'b0;
        if ((count_q == {CW{1'b0}}) || pop_s) begin
            wait_d  = 8'd0;
            stall_d = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
            wait_d  = wait_q;
            stall_d = 1'b1;
        end else begin
            wait_d  = wait_q + 8'd1;
            stall_d = 1'b0;
        end
    end

    // Output stage next state: granted fields load, otherwise data holds.
    always_comb begin
        reg_we_d = 1'b0;
        reg_wa_d = reg_wa_q;
        reg_wd_d = reg_wd_q;
        reg_pc_d = reg_pc_q;
        if (grant_a_s) begin
            reg_we_d = 1'b1;
            reg_wa_d = wbWA;
            reg_wd_d = wbWD;
            reg_pc_d = wbPC;
        end else if (pop_s) begin
            reg_we_d = 1'b1;
            reg_wa_d = wa_mem_q[rd_ptr_q];
            reg_wd_d = wd_mem_q[rd_ptr_q];
            reg_pc_d = pc_mem_q[rd_ptr_q];
        end else begin
            reg_we_d = 1'b0;
        end
    end

    // Scoreboard: match queries against live FIFO entries and the output stage.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        idx_s  = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                if (wa_mem_q[idx_s] == qA1) hit1_s = 1'b1;
                if (wa_mem_q[idx_s] == qA2) hit2_s = 1'b1;
            end else begin
                hit1_s = hit1_s;
                hit2_s = hit2_s;
            end
        end
        qBusy1 = (qA1 != 5'd0) && (hit1_s || (reg_we_q && (reg_wa_q == qA1)));
        qBusy2 = (qA2 != 5'd0) && (hit2_s || (reg_we_q && (reg_wa_q == qA2)));
    end

    // Control state, output stage and FIFO storage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            wait_q   <= 8'd0;
            stall_q  <= 1'b0;
            reg_we_q <= 1'b0;
            reg_wa_q <= 5'd0;
            reg_wd_q <= 32'd0;
            reg_pc_q <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                wa_mem_q[i] <= 5'd0;
                wd_mem_q[i] <= 32'd0;
                pc_mem_q[i] <= 32'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            reg_we_q <= reg_we_d;
            reg_wa_q <= reg_wa_d;
            reg_wd_q <= reg_wd_d;
            reg_pc_q <= reg_pc_d;
            if (push_s) begin
                wa_mem_q[wr_ptr_q] <= mdWA;
                wd_mem_q[wr_ptr_q] <= mdWD;
                pc_mem_q[wr_ptr_q] <= mdPC;
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed testbench for grf_wb_arbiter (DEPTH=4, MAX_WAIT=8).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbWE;
    logic [4:0]  wbWA;
    logic [31:0] wbWD, wbPC;
    logic        mdValid;
    logic        mdReady;
    logic [4:0]  mdWA;
    logic [31:0] mdWD, mdPC;
    logic [4:0]  qA1, qA2;
    logic        qBusy1, qBusy2;
    logic [2:0]  qCount;
    logic        pipeStall;
    logic        regWE;
    logic [4:0]  regWA;
    logic [31:0] regWD, PC;

    int errors = 0;
    int checks = 0;
    int stall_at;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset),
        .wbWE(wbWE), .wbWA(wbWA), .wbWD(wbWD), .wbPC(wbPC),
        .mdValid(mdValid), .mdReady(mdReady), .mdWA(mdWA), .mdWD(mdWD), .mdPC(mdPC),
        .qA1(qA1), .qA2(qA2), .qBusy1(qBusy1), .qBusy2(qBusy2),
        .qCount(qCount), .pipeStall(pipeStall),
        .regWE(regWE), .regWA(regWA), .regWD(regWD), .PC(PC)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        reset = 1'b0; wbWE = 1'b0; wbWA = 5'd0; wbWD = 32'd0; wbPC = 32'd0;
        mdValid = 1'b0; mdWA = 5'd0; mdWD = 32'd0; mdPC = 32'd0;
        qA1 = 5'd0; qA2 = 5'd0;

        // Reset state
        tick; tick;
        chk("rst_mdReady", {31'd0, mdReady}, 32'd0);
        chk("rst_regWE", {31'd0, regWE}, 32'd0);
        chk("rst_qCount", {29'd0, qCount}, 32'd0);
        chk("rst_stall", {31'd0, pipeStall}, 32'd0);
        chk("rst_regWD", regWD, 32'd0);
        reset = 1'b1;
        tick;
        chk("rel_mdReady", {31'd0, mdReady}, 32'd1);
        chk("rel_regWE", {31'd0, regWE}, 32'd0);

        // A only
        wbWE = 1'b1; wbWA = 5'd5; wbWD = 32'h1234; wbPC = 32'h3000;
        tick;
        chk("a_regWE", {31'd0, regWE}, 32'd1);
        chk("a_regWA", {27'd0, regWA}, 32'd5);
        chk("a_regWD", regWD, 32'h1234);
        chk("a_PC", PC, 32'h3000);
        wbWE = 1'b0;
        tick;
        chk("a_idle_regWE", {31'd0, regWE}, 32'd0);
        chk("a_hold_regWA", {27'd0, regWA}, 32'd5);

        // B with A idle
        mdValid = 1'b1; mdWA = 5'd8; mdWD = 32'hCAFE; mdPC = 32'h100;
        tick;
        chk("b_nobypass_regWE", {31'd0, regWE}, 32'd0);
        chk("b_qCount1", {29'd0, qCount}, 32'd1);
        mdWA = 5'd9; mdWD = 32'hBEEF; mdPC = 32'h104;
        tick;
        mdValid = 1'b0;
        chk("b1_regWE", {31'd0, regWE}, 32'd1);
        chk("b1_regWA", {27'd0, regWA}, 32'd8);
        chk("b1_regWD", regWD, 32'hCAFE);
        chk("b1_qCount", {29'd0, qCount}, 32'd1);
        tick;
        chk("b2_regWE", {31'd0, regWE}, 32'd1);
        chk("b2_regWA", {27'd0, regWA}, 32'd9);
        chk("b2_PC", PC, 32'h104);
        chk("b2_qCount", {29'd0, qCount}, 32'd0);
        tick;
        chk("b_idle_regWE", {31'd0, regWE}, 32'd0);

        // Fill and full with A saturating the port
        wbWE = 1'b1; wbWA = 5'd1; wbWD = 32'h1111; wbPC = 32'h2000;
        mdValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mdWA = 5'(10 + i); mdWD = 32'hA0 + 32'(i); mdPC = 32'h400 + 32'(4 * i);
            tick;
        end
        chk("full_mdReady", {31'd0, mdReady}, 32'd0);
        chk("full_qCount", {29'd0, qCount}, 32'd4);
        mdWA = 5'd14; mdWD = 32'hEE; mdPC = 32'h500;
        tick;
        mdValid = 1'b0;
        chk("full_refuse_qCount", {29'd0, qCount}, 32'd4);
        qA1 = 5'd14; qA2 = 5'd13;
        #1;
        chk("full_refuse_busy", {31'd0, qBusy1}, 32'd0);
        chk("full_tail_busy", {31'd0, qBusy2}, 32'd1);

        // Starvation: freeze expected 4 edges after the refused push
        stall_at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            if (pipeStall === 1'b1 && stall_at == 0) stall_at = i;
            if (stall_at != 0) break;
        end
        chk("stall_cycle", stall_at, 32'd4);
        chk("stall_a_regWA", {27'd0, regWA}, 32'd1);
        wbWE = 1'b0;
        tick;
        chk("stall_clear", {31'd0, pipeStall}, 32'd0);
        chk("stall_b_regWE", {31'd0, regWE}, 32'd1);
        chk("stall_b_regWA", {27'd0, regWA}, 32'd10);
        chk("stall_b_regWD", regWD, 32'hA0);
        chk("stall_qCount", {29'd0, qCount}, 32'd3);
        wbWE = 1'b1;
        tick;
        chk("resume_a_regWA", {27'd0, regWA}, 32'd1);
        chk("resume_a_regWE", {31'd0, regWE}, 32'd1);
        chk("resume_nostall", {31'd0, pipeStall}, 32'd0);
        wbWE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("drain_regWA", {27'd0, regWA}, 32'(11 + i));
            chk("drain_PC", PC, 32'h404 + 32'(4 * i));
        end
        chk("drain_qCount", {29'd0, qCount}, 32'd0);
        tick;
        chk("drain_idle", {31'd0, regWE}, 32'd0);

        // Scoreboard
        wbWE = 1'b1; wbWA = 5'd2; wbWD = 32'h22; wbPC = 32'h600;
        mdValid = 1'b1; mdWA = 5'd7; mdWD = 32'h77; mdPC = 32'h700;
        tick;
        mdValid = 1'b0;
        qA1 = 5'd7; qA2 = 5'd0;
        #1;
        chk("sb_busy1", {31'd0, qBusy1}, 32'd1);
        chk("sb_zero", {31'd0, qBusy2}, 32'd0);
        qA2 = 5'd2;
        #1;
        chk("sb_outstage_a", {31'd0, qBusy2}, 32'd1);
        wbWE = 1'b0;
        tick;
        chk("sb_b_regWA", {27'd0, regWA}, 32'd7);
        chk("sb_busy_outstage", {31'd0, qBusy1}, 32'd1);
        tick;
        chk("sb_commit_drop", {31'd0, qBusy1}, 32'd0);

        // Reset mid-queue
        wbWE = 1'b1;
        mdValid = 1'b1;
        tick;
        mdValid = 1'b0;
        chk("mid_qCount", {29'd0, qCount}, 32'd1);
        chk("mid_busy", {31'd0, qBusy1}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, qBusy1}, 32'd0);
        chk("mid_rst_qCount", {29'd0, qCount}, 32'd0);
        chk("mid_rst_regWE", {31'd0, regWE}, 32'd0);
        chk("mid_rst_mdReady", {31'd0, mdReady}, 32'd0);
        wbWE = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        chk("post_rst_regWE", {31'd0, regWE}, 32'd0);
        chk("post_rst_qCount", {29'd0, qCount}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
